// File: rtl/multichan_sinegen.sv
// -----------------------------------------------------------------------------
// multichan_sinegen
//
// N-channel direct-digital sine generator. One fractional phase accumulator
// drives N_CH parallel reads of a single shared sine table. Each channel adds
// its own programmable phase offset (in table entries) before the lookup. It
// then scales the looked-up sample about mid-scale by its own amplitude.
//
// Pipeline:
//   acc (edge k) -> rom_q (edge k+1) -> dout (edge k+2)
//   valid follows en through a matching 3-deep delay line.
//
// Parameters:
//   A_WIDTH  sine table address width, table depth 2**A_WIDTH
//   D_WIDTH  sample width, unsigned offset-binary around 2**(D_WIDTH-1)
//   F_WIDTH  fractional accumulator bits (sub-sample frequency resolution)
//   N_CH     number of output channels (1..16)
//   ROM_FILE name of the equivalent hex image. The table is computed at
//            elaboration from the same formula:
//            round(2**(D-1) + (2**(D-1)-1) * sin(2*pi*i/2**A)).
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        asynchronous, active-low reset
//   en         accumulator advance enable
//   sync       synchronous phase clear, has priority over en
//   incr       per-cycle accumulator increment (A_WIDTH+F_WIDTH bits)
//   cfg_we     config write strobe
//   cfg_ch     channel being configured; values >= N_CH are ignored
//   cfg_phase  phase offset in table entries
//   cfg_amp    amplitude, all-ones is (almost) full scale
//   dout       channel c at dout[c*D_WIDTH +: D_WIDTH]
//   valid      dout reflects an accumulator step taken under en
// -----------------------------------------------------------------------------
module multichan_sinegen #(
    parameter int A_WIDTH  = 8,
    parameter int D_WIDTH  = 8,
    parameter int F_WIDTH  = 8,
    parameter int N_CH     = 2,
    parameter     ROM_FILE = "sinerom.mem",
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int ACC_W   = A_WIDTH + F_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      sync,
    input  logic [ACC_W-1:0]          incr,
    input  logic                      cfg_we,
    input  logic [CH_W-1:0]           cfg_ch,
    input  logic [A_WIDTH-1:0]        cfg_phase,
    input  logic [D_WIDTH-1:0]        cfg_amp,
    output logic [N_CH*D_WIDTH-1:0]   dout,
    output logic                      valid
);

    localparam int                 DEPTH   = 1 << A_WIDTH;
    localparam int                 MID     = 1 << (D_WIDTH - 1);
    localparam logic [D_WIDTH-1:0] MID_D   = D_WIDTH'(MID);
    localparam logic [D_WIDTH:0]   MID_EXT = (D_WIDTH + 1)'(MID);

    // One table entry, rounded to nearest. The value is always positive, so
    // truncation after adding 0.5 is a correct round-half-up.
    function automatic logic [D_WIDTH-1:0] sine_entry(input int idx);
        real ang;
        real val;
        int  r;
        ang = 2.0 * 3.14159265358979323846 * real'(idx) / real'(DEPTH);
        val = real'(MID) + real'(MID - 1) * $sin(ang) + 0.5;
        r   = $rtoi(val);
        return r[D_WIDTH-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Shared sine table (read-only, every channel has its own read port)
    // ------------------------------------------------------------------
    logic [D_WIDTH-1:0] sine_rom [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
        localparam logic [D_WIDTH-1:0] ENTRY = sine_entry(gi);
        assign sine_rom[gi] = ENTRY;
    end

    // ------------------------------------------------------------------
    // Phase accumulator
    // ------------------------------------------------------------------
    logic [ACC_W-1:0]   acc_reg;
    logic [ACC_W-1:0]   acc_next;
    logic [A_WIDTH-1:0] phase_int;

    always_comb begin
        acc_next = acc_reg;
        if (sync) begin
            acc_next = '0;
        end else if (en) begin
            acc_next = acc_reg + incr;          // wraps modulo 2**ACC_W
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_reg <= '0;
        end else begin
            acc_reg <= acc_next;
        end
    end

    // Fractional bits are simply dropped (truncation, not rounding).
    assign phase_int = acc_reg[ACC_W-1:F_WIDTH];

    // ------------------------------------------------------------------
    // valid delay line, aligned with the two pipeline stages after acc
    // ------------------------------------------------------------------
    logic v1_reg;
    logic v2_reg;
    logic valid_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_reg    <= 1'b0;
            v2_reg    <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            v1_reg    <= en;
            v2_reg    <= v1_reg;
            valid_reg <= v2_reg;
        end
    end

    assign valid = valid_reg;

    // ------------------------------------------------------------------
    // Per-channel config, table read and amplitude scaling
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [A_WIDTH-1:0]          phase_reg;
        logic [D_WIDTH-1:0]          amp_reg;
        logic [D_WIDTH-1:0]          rom_q_reg;
        logic [D_WIDTH-1:0]          dout_reg;
        logic [D_WIDTH-1:0]          dout_next;
        logic [A_WIDTH-1:0]          addr;
        logic                        cfg_hit;
        logic signed [D_WIDTH:0]     centred;
        logic signed [D_WIDTH:0]     amp_s;
        logic signed [2*D_WIDTH:0]   prod;

        // An out-of-range cfg_ch matches no channel, so the write is dropped.
        assign cfg_hit = cfg_we && (cfg_ch == CH_W'(gi));

        // Offset add wraps naturally within the table.
        assign addr = phase_int + phase_reg;

        // Sample re-centred around zero, then scaled by amp / 2**D_WIDTH.
        // The arithmetic shift floors, and the result always fits in the
        // unsigned output range, so no clamping is required.
        assign centred   = $signed({1'b0, rom_q_reg}) - $signed(MID_EXT);
        assign amp_s     = $signed({1'b0, amp_reg});
        assign prod      = centred * amp_s;
        assign dout_next = D_WIDTH'((prod >>> D_WIDTH) + MID);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                phase_reg <= '0;
                amp_reg   <= '1;
                rom_q_reg <= MID_D;
                dout_reg  <= MID_D;
            end else begin
                if (cfg_hit) begin
                    phase_reg <= cfg_phase;
                    amp_reg   <= cfg_amp;
                end
                rom_q_reg <= sine_rom[addr];
                // amp_reg is applied directly to the already-registered
                // sample, so an amplitude write shows one edge later.
                dout_reg  <= dout_next;
            end
        end

        assign dout[gi*D_WIDTH +: D_WIDTH] = dout_reg;
    end

endmodule

// File: tb/tb_multichan_sinegen.sv
// -----------------------------------------------------------------------------
// tb_multichan_sinegen
//
// Directed bench for multichan_sinegen, built with three channels so that
// cfg_ch = 3 is a representable out-of-range channel. Every task drives its
// own stimulus and compares DUT outputs inline. The expected values are
// hand-derived constants at the interesting points. They are backed by a
// small cycle model of the accumulator, table lookup and scaling equations.
// -----------------------------------------------------------------------------
module tb_multichan_sinegen;

    localparam int A  = 8;
    localparam int D  = 8;
    localparam int F  = 8;
    localparam int NC = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              sync;
    logic [A+F-1:0]    incr;
    logic              cfg_we;
    logic [1:0]        cfg_ch;
    logic [A-1:0]      cfg_phase;
    logic [D-1:0]      cfg_amp;
    logic [NC*D-1:0]   dout;
    logic              valid;

    int checks = 0;
    int errors = 0;

    int tb_sine [256];

    // reference model state
    int m_acc;
    int m_phase [NC];
    int m_amp   [NC];
    int m_q     [NC];
    int m_qa    [NC];
    int m_dout  [NC];
    int m_da    [NC];
    int m_v1;
    int m_v2;
    int m_valid;

    multichan_sinegen #(
        .A_WIDTH (A),
        .D_WIDTH (D),
        .F_WIDTH (F),
        .N_CH    (NC),
        .ROM_FILE("sinerom.mem")
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sync     (sync),
        .incr     (incr),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_phase(cfg_phase),
        .cfg_amp  (cfg_amp),
        .dout     (dout),
        .valid    (valid)
    );

    always #5 clk = ~clk;

    function automatic int scale(input int q, input int amp);
        int p;
        p = (q - 128) * amp;
        return (p >>> 8) + 128;
    endfunction

    task automatic model_reset();
        m_acc = 0;
        for (int c = 0; c < NC; c++) begin
            m_phase[c] = 0;
            m_amp[c]   = 255;
            m_q[c]     = 128;
            m_qa[c]    = -1;
            m_dout[c]  = 128;
            m_da[c]    = -1;
        end
        m_v1    = 0;
        m_v2    = 0;
        m_valid = 0;
    endtask

    // Advance the model with the inputs as currently driven, then clock the
    // DUT and return 1 time unit after the edge.
    task automatic tick();
        int p;
        int nq [NC];
        int nqa[NC];
        int nd [NC];
        int nda[NC];
        if (rst) begin
            p = (m_acc >> 8) & 255;
            for (int c = 0; c < NC; c++) begin
                nd[c]  = scale(m_q[c], m_amp[c]);
                nda[c] = m_qa[c];
                nqa[c] = (p + m_phase[c]) & 255;
                nq[c]  = tb_sine[nqa[c]];
            end
            m_valid = m_v2;
            m_v2    = m_v1;
            m_v1    = int'(en);
            if (sync)    m_acc = 0;
            else if (en) m_acc = (m_acc + int'(incr)) & 16'hffff;
            if (cfg_we && cfg_ch < NC) begin
                m_phase[cfg_ch] = int'(cfg_phase);
                m_amp[cfg_ch]   = int'(cfg_amp);
            end
            for (int c = 0; c < NC; c++) begin
                m_q[c]    = nq[c];
                m_qa[c]   = nqa[c];
                m_dout[c] = nd[c];
                m_da[c]   = nda[c];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < NC; c++) begin
                checks++;
                if (dout[c*D +: D] !== 8'd128) begin
                    errors++;
                    $display("FAIL reset_dout%0d pass %0d: got %0d expected 128", c, r, dout[c*D +: D]);
                end
            end
            checks++;
            if (valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_valid pass %0d: got %b expected 0", r, valid);
            end
            tick();
            tick();
        end
        rst = 1'b1;
        $display("reset released at %0t", $time);
    endtask

    task automatic test_defaults();
        en   = 1'b1;
        incr = 16'h0100;
        for (int m = 1; m <= 70; m++) begin
            tick();
            for (int c = 0; c < NC; c++) begin
                checks++;
                if (dout[c*D +: D] !== D'(m_dout[c])) begin
                    errors++;
                    $display("FAIL defaults_dout%0d step %0d: got %0d expected %0d", c, m, dout[c*D +: D], m_dout[c]);
                end
            end
            if (m <= 3) begin
                checks++;
                if (valid !== (m == 3)) begin
                    errors++;
                    $display("FAIL defaults_valid_rise step %0d: got %b expected %b", m, valid, (m == 3));
                end
            end
            if (m == 2 || m == 3 || m == 66) begin
                checks++;
                if (dout[0 +: D] !== ((m == 2) ? 8'd128 : (m == 3) ? 8'd130 : 8'd254)) begin
                    errors++;
                    $display("FAIL defaults_hand step %0d: got %0d", m, dout[0 +: D]);
                end
            end
        end
        $display("defaults: 70 steps done, checks %0d", checks);
    endtask

    task automatic test_quadrature();
        int hits = 0;
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_phase = 8'd64; cfg_amp = 8'd255;
        tick();
        cfg_we = 1'b0;
        for (int i = 1; i <= 260; i++) begin
            tick();
            for (int c = 0; c < NC; c++) begin
                checks++;
                if (dout[c*D +: D] !== D'(m_dout[c])) begin
                    errors++;
                    $display("FAIL quad_dout%0d step %0d: got %0d expected %0d", c, i, dout[c*D +: D], m_dout[c]);
                end
            end
            if (i > 2 && m_da[0] == 0) begin
                hits++;
                checks++;
                if (dout[0 +: D] !== 8'd128 || dout[D +: D] !== 8'd254) begin
                    errors++;
                    $display("FAIL quad_lead step %0d: got ch0 %0d ch1 %0d expected 128 254", i, dout[0 +: D], dout[D +: D]);
                end
            end
        end
        checks++;
        if (hits != 1) begin
            errors++;
            $display("FAIL quad_addr0_seen: got %0d expected 1", hits);
        end
        $display("quadrature: addr-0 alignment points %0d", hits);
    endtask

    task automatic test_amplitude();
        int hits = 0;
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_phase = 8'd0; cfg_amp = 8'd128;
        tick();
        cfg_we = 1'b0;
        for (int i = 1; i <= 260; i++) begin
            tick();
            checks++;
            if (dout[0 +: D] !== D'(m_dout[0])) begin
                errors++;
                $display("FAIL amp_dout0 step %0d: got %0d expected %0d", i, dout[0 +: D], m_dout[0]);
            end
            if (i > 1 && (m_da[0] == 64 || m_da[0] == 192 || m_da[0] == 128)) begin
                hits++;
                checks++;
                if (dout[0 +: D] !== ((m_da[0] == 64) ? 8'd191 : (m_da[0] == 192) ? 8'd64 : 8'd128)) begin
                    errors++;
                    $display("FAIL amp_half addr %0d: got %0d", m_da[0], dout[0 +: D]);
                end
            end
        end
        checks++;
        if (hits < 3) begin
            errors++;
            $display("FAIL amp_points_seen: got %0d expected at least 3", hits);
        end
        cfg_we = 1'b1; cfg_amp = 8'd0;
        tick();
        cfg_we = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            checks++;
            if (dout[0 +: D] !== 8'd128) begin
                errors++;
                $display("FAIL amp_zero step %0d: got %0d expected 128", i, dout[0 +: D]);
            end
        end
        cfg_we = 1'b1; cfg_amp = 8'd255;
        tick();
        cfg_we = 1'b0;
        $display("amplitude: half-scale points %0d, zero-amp hold checked", hits);
    endtask

    task automatic test_fractional();
        sync = 1'b1;
        incr = 16'h0080;
        tick();
        sync = 1'b0;
        for (int i = 1; i <= 512; i++) begin
            tick();
            for (int c = 0; c < NC; c++) begin
                checks++;
                if (dout[c*D +: D] !== D'(m_dout[c])) begin
                    errors++;
                    $display("FAIL frac_dout%0d step %0d: got %0d expected %0d", c, i, dout[c*D +: D], m_dout[c]);
                end
            end
        end
        en = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (dout[0 +: D] !== 8'd128 || dout[D +: D] !== 8'd254 || valid !== 1'b0) begin
            errors++;
            $display("FAIL frac_wrap: got ch0 %0d ch1 %0d valid %b expected 128 254 0", dout[0 +: D], dout[D +: D], valid);
        end
        $display("fractional: 512 half-steps, frozen at ch0 %0d ch1 %0d", dout[0 +: D], dout[D +: D]);
    endtask

    task automatic test_sync_en();
        en   = 1'b1;
        incr = 16'h0100;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (dout[0 +: D] !== D'(m_dout[0])) begin
                errors++;
                $display("FAIL sync_pre_dout0 step %0d: got %0d expected %0d", i, dout[0 +: D], m_dout[0]);
            end
        end
        sync = 1'b1;
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_phase = 8'd192; cfg_amp = 8'd255;
        tick();
        sync = 1'b0;
        cfg_we = 1'b0;
        tick();
        tick();
        checks++;
        if (dout[0 +: D] !== 8'd128 || dout[D +: D] !== 8'd254 || dout[2*D +: D] !== 8'd1) begin
            errors++;
            $display("FAIL sync_en_phase: got %0d %0d %0d expected 128 254 1", dout[0 +: D], dout[D +: D], dout[2*D +: D]);
        end
        checks++;
        if (valid !== 1'b1) begin
            errors++;
            $display("FAIL sync_valid: got %b expected 1", valid);
        end
        $display("sync+en: outputs %0d %0d %0d", dout[0 +: D], dout[D +: D], dout[2*D +: D]);
    endtask

    task automatic test_en_gap();
        for (int i = 1; i <= 5; i++) tick();
        en = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            tick();
            checks++;
            if (valid !== (j <= 2)) begin
                errors++;
                $display("FAIL gap_valid_fall step %0d: got %b expected %b", j, valid, (j <= 2));
            end
            for (int c = 0; c < NC; c++) begin
                checks++;
                if (dout[c*D +: D] !== D'(m_dout[c])) begin
                    errors++;
                    $display("FAIL gap_dout%0d step %0d: got %0d expected %0d", c, j, dout[c*D +: D], m_dout[c]);
                end
            end
        end
        en = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            tick();
            checks++;
            if (valid !== (j >= 3)) begin
                errors++;
                $display("FAIL gap_valid_rise step %0d: got %b expected %b", j, valid, (j >= 3));
            end
        end
        $display("en gap: valid fall/rise checked");
    endtask

    task automatic test_async_reset();
        tick();
        #3;
        rst = 1'b0;
        #1;
        for (int c = 0; c < NC; c++) begin
            checks++;
            if (dout[c*D +: D] !== 8'd128) begin
                errors++;
                $display("FAIL async_rst_dout%0d: got %0d expected 128", c, dout[c*D +: D]);
            end
        end
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL async_rst_valid: got %b expected 0", valid);
        end
        model_reset();
        tick();
        tick();
        rst    = 1'b1;
        en     = 1'b1;
        incr   = 16'h0100;
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_phase = 8'd10; cfg_amp = 8'd5;
        tick();
        cfg_we = 1'b0;
        for (int m = 2; m <= 66; m++) begin
            tick();
            for (int c = 0; c < NC; c++) begin
                checks++;
                if (dout[c*D +: D] !== D'(m_dout[c])) begin
                    errors++;
                    $display("FAIL post_rst_dout%0d step %0d: got %0d expected %0d", c, m, dout[c*D +: D], m_dout[c]);
                end
            end
        end
        for (int c = 0; c < NC; c++) begin
            checks++;
            if (dout[c*D +: D] !== 8'd254) begin
                errors++;
                $display("FAIL bad_ch_write_dout%0d: got %0d expected 254", c, dout[c*D +: D]);
            end
        end
        $display("async reset and out-of-range cfg write checked");
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; sync = 1'b0; incr = '0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_phase = '0; cfg_amp = '0;
        for (int i = 0; i < 256; i++) begin
            tb_sine[i] = $rtoi(128.0 + 127.0 * $sin(2.0 * 3.14159265358979323846 * i / 256.0) + 0.5);
        end
        model_reset();
        #12;
        test_reset();
        test_defaults();
        test_quadrature();
        test_amplitude();
        test_fractional();
        test_sync_en();
        test_en_gap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multichan_sinegen.md
# multichan_sinegen

Parametrised N-channel direct-digital sine generator: a fractional phase accumulator drives N_CH parallel reads of one shared sine table. Each channel has its own run-time programmable phase offset and amplitude. Successor to the two-output sine generator. It sits between the rotary/config front end and the output DACs/plotter. Frequency resolution is sub-sample (fractional increment), and outputs carry a valid flag.

## Interface
- A_WIDTH, 8, sine table address width (table depth 2^A_WIDTH)
- D_WIDTH, 8, sample width, unsigned offset-binary (midpoint 2^(D_WIDTH-1))
- F_WIDTH, 8, fractional accumulator bits
- N_CH, 2, number of output channels (1..16)
- ROM_FILE, "sinerom.mem", hex init file, entry i = round(2^(D_WIDTH-1) + (2^(D_WIDTH-1)-1)·sin(2πi/2^A_WIDTH))
- clk  input  1  clock; all state on rising edge
- rst  input  1  asynchronous, active-low reset
- en  input  1  accumulator advance enable
- sync  input  1  synchronous phase clear, priority over en
- incr  input  A_WIDTH+F_WIDTH  per-cycle accumulator increment
- cfg_we  input  1  config write strobe
- cfg_ch  input  max(1,$clog2(N_CH))  channel being configured
- cfg_phase  input  A_WIDTH  phase offset, in table entries
- cfg_amp  input  D_WIDTH  amplitude, 2^D_WIDTH-1 ≈ full scale
- dout  output  N_CH·D_WIDTH  channel c at [c·D_WIDTH +: D_WIDTH]
- valid  output  1  dout reflects an accumulator step taken under en

## Operation
- Accumulator acc (A_WIDTH+F_WIDTH bits). At each edge: if sync, acc←0; else if en, acc←acc+incr, wrapping modulo 2^(A_WIDTH+F_WIDTH); else acc holds.
- Integer phase p = acc[A_WIDTH+F_WIDTH-1:F_WIDTH]. Fractional bits are truncated, not rounded.
- Per channel: addr_c = (p + phase_c) mod 2^A_WIDTH. This is combinational from registered acc and phase_c.
- Stage 1: rom_q_c ← table[addr_c] for every channel every cycle (registered read).
- Stage 2 (scale): s = rom_q_c − 2^(D_WIDTH-1) as signed D_WIDTH+1 bits; prod = s·cfg amp_c (signed 2·D_WIDTH+1 bits); dout_c ← (prod >>> D_WIDTH) + 2^(D_WIDTH-1), truncated to D_WIDTH. The shift is arithmetic (floor). No saturation is needed: the result always lies in 0..2^D_WIDTH-1.
- Config: on an edge with cfg_we=1 and cfg_ch<N_CH, phase_cfg_ch←cfg_phase and amp_cfg_ch←cfg_amp. A write with cfg_ch≥N_CH is ignored.
- Stages 1–2 advance every cycle regardless of en. With en=0, dout settles to a constant (the frozen phase) and valid deasserts.
- valid: 3-bit shift chain v1←en, v2←v1, valid←v2. sync does not affect valid.

## Timing
- Reset (rst=0, async): acc=0, all phase_c=0, all amp_c=2^D_WIDTH-1, rom_q_c=2^(D_WIDTH-1), dout_c=2^(D_WIDTH-1), v1=v2=valid=0.
- Reset mid-operation: all of the above happen immediately; no partial samples emerge after release.
- First active edge after rst release: rst deassertion is synchronised externally; the block only requires rst to be stable around the edges.
- Latency: acc updated at edge k → rom_q at edge k+1 → dout at edge k+2. valid at edge k+2 equals en sampled at edge k.
- Config write at edge k affects addr at cycle k→k+1 and appears on dout at edge k+2 (phase) or k+1 for the amplitude term applied to the rom_q already registered. Amp is used combinationally in stage 2.
- sync at edge k: dout at k+2 = scaled table[phase_c] for each channel.
- Wrap: acc wraps silently. incr=0 with en=1 holds the phase and keeps valid=1.
- sync and en both high: acc←0 (not 0+incr).
- sync and cfg_we at the same edge: both take effect independently.

## Test plan
- Defaults, incr=0x100, en=1 after reset: dout_0 = 128, 128+…, reaching 254 at the step where addr=64 (amp 255: s=127 → 126+128). valid rises exactly 3 edges after en is first sampled high.
- Quadrature: cfg ch1 phase=64, amp=255: whenever dout_0=128 from addr 0, dout_1=254. Channel 1 leads channel 0 by 64 entries for the full 256-step period.
- Amplitude: ch0 amp=128. Table value 255 gives dout 191, table value 1 gives dout 64, table value 128 gives 128. amp=0 gives a constant 128.
- Fractional step, incr=0x080: each table address repeats for exactly 2 cycles. Over 512 en cycles the accumulator wraps to 0 exactly once.
- sync+en asserted together mid-stream: acc=0 afterwards, and dout at +2 edges equals scaled table[phase_c]. Independently, en=0 for 5 cycles: dout constant, valid=0 two edges after en drops (3rd edge), then recovers.
- Async reset asserted mid-stream between edges: dout=128 and valid=0 immediately. A cfg write with cfg_ch=N_CH leaves all phases and amps unchanged.
